// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample input and I2S/status output bundle for i2s_tx
interface i2s_tx_if;
  logic        sample_ce;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        i2s_sclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        overrun;
  logic        underrun;
  logic [2:0]  fifo_level;
  modport master (
    output sample_ce, audio_l, audio_r,
    input  i2s_sclk, i2s_lrclk, i2s_sdata, overrun, underrun, fifo_level
  );
  modport slave (
    input  sample_ce, audio_l, audio_r,
    output i2s_sclk, i2s_lrclk, i2s_sdata, overrun, underrun, fifo_level
  );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: 4-deep stereo FIFO feeding a 64-bit-frame I2S serializer; define I2S_TX_HOLD_EN to repeat the last frame on underrun
module i2s_tx #(
  parameter int CLK_RATE   = 24576000,
  parameter int AUDIO_RATE = 48000
) (
  input logic   clk,
  input logic   reset,
  i2s_tx_if.slave bus
);
  localparam int HALF_DIV = CLK_RATE / (AUDIO_RATE * 128);
  localparam int DW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  logic [DW-1:0] div_q;
  logic          sclk_q, lrclk_q, sdata_q, ovr_q, und_q;
  logic [5:0]    p_q, p_d;
  logic [31:0]   mem_q [4];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q;
  logic [31:0]   sh_q, fallback;
  logic          tick, fall, frame_start, pop, push, shift_bit;
`ifdef I2S_TX_HOLD_EN
  logic [31:0]   hold_q;
  assign fallback = hold_q;
`else
  assign fallback = '0;
`endif
  always_comb begin
    tick        = div_q == DW'(HALF_DIV - 1);
    fall        = tick & sclk_q;
    p_d         = p_q + 6'd1;
    frame_start = fall & (p_d == 6'd0);
    pop         = frame_start & (cnt_q != 3'd0);
    push        = ~reset & bus.sample_ce & ((cnt_q != 3'd4) | pop);
    // data occupies slot positions 1..16 of each 32-bit half
    shift_bit   = (p_d[4:0] != 5'd0) & (p_d[4:0] <= 5'd16);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {bus.audio_l, bus.audio_r};
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
      p_q     <= 6'd63;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
`ifdef I2S_TX_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) sclk_q <= ~sclk_q;
      ovr_q <= bus.sample_ce & ~push;
      und_q <= frame_start & (cnt_q == 3'd0);
      if (fall) begin
        p_q     <= p_d;
        lrclk_q <= p_d[5];
        sdata_q <= shift_bit & sh_q[31];
        if (frame_start) sh_q <= pop ? mem_q[rp_q] : fallback;
        else if (shift_bit) sh_q <= {sh_q[30:0], 1'b0};
      end
      if (pop) begin
        rp_q <= rp_q + 2'd1;
`ifdef I2S_TX_HOLD_EN
        hold_q <= mem_q[rp_q];
`endif
      end
      if (push) wp_q <= wp_q + 2'd1;
      cnt_q <= cnt_q + 3'(push) - 3'(pop);
    end
  end
  assign bus.i2s_sclk   = sclk_q;
  assign bus.i2s_lrclk  = lrclk_q;
  assign bus.i2s_sdata  = sdata_q;
  assign bus.overrun    = ovr_q;
  assign bus.underrun   = und_q;
  assign bus.fifo_level = cnt_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: vector table plus frame scoreboard for i2s_tx at default rates
module tb_i2s_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  i2s_tx_if bus();
  i2s_tx dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          gap;
    logic [2:0]  lvl;
    logic        ovr;
  } vec_t;
  vec_t tbl [8];
  int checks = 0;
  int errors = 0;
  int t = 0;
  int nfr = 0;
  int per;
  int n;
  bit chk_en = 1'b0;
  logic [31:0] mq [$];
  logic [31:0] sb [$];
  logic [31:0] held = '0;
  logic [31:0] fr;
  logic [31:0] efr;
  logic e_und = 1'b0;
  logic e_ovr = 1'b0;
  logic rx_ps = 1'b0;
  logic rx_plr = 1'b1;
  bit rx_coll = 1'b0;
  int rx_pos = 0;
  logic [63:0] rx_v = '0;
  localparam logic [63:0] MASK = 64'h7FFF_8000_7FFF_8000;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model: FIFO contents and frame timing counted in clk cycles since reset
  initial forever begin
    @(posedge clk);
    if (reset) begin
      t = 0;
      mq.delete();
      sb.delete();
      held = '0;
      e_und = 1'b0;
      e_ovr = 1'b0;
      chk_en = 1'b1;
    end else begin
      t++;
      e_und = 1'b0;
      e_ovr = 1'b0;
      if (t % 512 == 8) begin
        if (mq.size() != 0) begin
          fr = mq.pop_front();
          held = fr;
        end else begin
          e_und = 1'b1;
`ifdef I2S_TX_HOLD_EN
          fr = held;
`else
          fr = '0;
`endif
        end
        sb.push_back(fr);
      end
      if (bus.sample_ce) begin
        if (mq.size() < 4) mq.push_back({bus.audio_l, bus.audio_r});
        else e_ovr = 1'b1;
      end
    end
  end

  // pin checks every cycle and an I2S receiver sampling SDATA on SCLK rising
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("sclk", bus.i2s_sclk, 64'((t >> 2) & 1));
      chk("lrclk", bus.i2s_lrclk, 64'(((63 + (t >> 3)) % 64) >= 32));
      chk("underrun", bus.underrun, e_und);
      chk("overrun", bus.overrun, e_ovr);
      chk("fifo_level", bus.fifo_level, 64'(mq.size()));
    end
    if (reset) begin
      rx_ps = 1'b0;
      rx_plr = 1'b1;
      rx_coll = 1'b0;
    end else begin
      if (bus.i2s_sclk && !rx_ps) begin
        if (!bus.i2s_lrclk && rx_plr) begin
          rx_coll = 1'b1;
          rx_pos = 0;
        end else rx_pos++;
        rx_plr = bus.i2s_lrclk;
        if (rx_coll) begin
          rx_v[63 - rx_pos] = bus.i2s_sdata;
          if (rx_pos == 63) begin
            rx_coll = 1'b0;
            nfr++;
            if (sb.size() == 0) chk("frame_expected", 1, 0);
            else begin
              efr = sb.pop_front();
              chk("frame_data", {rx_v[62:47], rx_v[30:15]}, efr);
              chk("frame_pad", rx_v & ~MASK, 0);
            end
          end
        end
      end
      rx_ps = bus.i2s_sclk;
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    bus.sample_ce = 1'b1;
    bus.audio_l = l;
    bus.audio_r = r;
    @(negedge clk);
    bus.sample_ce = 1'b0;
  endtask

  task automatic wait_t(input int m);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (t % 512 == m) return;
    end
    chk("wait_timeout", 1, 0);
  endtask

  task automatic meas(input bit sel, output int p);
    logic pv, cv;
    int last;
    last = -1;
    p = -1;
    pv = sel ? bus.i2s_lrclk : bus.i2s_sclk;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cv = sel ? bus.i2s_lrclk : bus.i2s_sclk;
      if (cv && !pv) begin
        if (last >= 0) begin
          p = i - last;
          return;
        end
        last = i;
      end
      pv = cv;
    end
  endtask

  initial begin
    bus.sample_ce = 1'b0;
    bus.audio_l = '0;
    bus.audio_r = '0;
    tbl[0] = '{16'h1111, 16'h2222, 1, 3'd1, 1'b0};
    tbl[1] = '{16'h3333, 16'h4444, 0, 3'd2, 1'b0};
    tbl[2] = '{16'h5555, 16'h6666, 0, 3'd3, 1'b0};
    tbl[3] = '{16'h7777, 16'h8888, 0, 3'd4, 1'b0};
    tbl[4] = '{16'hDEAD, 16'hBEEF, 0, 3'd4, 1'b1};
    tbl[5] = '{16'h0001, 16'h8000, 1, 3'd4, 1'b0};
    tbl[6] = '{16'h1234, 16'h5678, 5, 3'd1, 1'b0};
    tbl[7] = '{16'hFFFF, 16'h0000, 3, 3'd1, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_sclk", bus.i2s_sclk, 0);
    chk("rst_lrclk", bus.i2s_lrclk, 1);
    chk("rst_sdata", bus.i2s_sdata, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_level", bus.fifo_level, 0);
    reset = 1'b0;
    send(16'hA5C3, 16'h0F01);
    chk("first_level", bus.fifo_level, 1);
    meas(1'b0, per);
    chk("sclk_period", per, 8);
    meas(1'b1, per);
    chk("lrclk_period", per, 512);
    chk("first_popped", bus.fifo_level, 0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < tbl[i].gap; g++) wait_t(8);
      send(tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d_level", i), bus.fifo_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_overrun", i), bus.overrun, tbl[i].ovr);
    end
    wait_t(8);
    chk("drained", bus.fifo_level, 0);
    wait_t(7);
    bus.sample_ce = 1'b1;
    bus.audio_l = 16'h0A0A;
    bus.audio_r = 16'hB0B0;
    @(negedge clk);
    bus.sample_ce = 1'b0;
    chk("empty_coinc_underrun", bus.underrun, 1);
    chk("empty_coinc_level", bus.fifo_level, 1);
    wait_t(8);
    chk("coinc_popped", bus.fifo_level, 0);
    for (int i = 1; i <= 4; i++) begin
      send(16'hC000 + 16'(i), 16'h0C00 + 16'(i));
      chk($sformatf("fill%0d_level", i), bus.fifo_level, i);
    end
    wait_t(7);
    bus.sample_ce = 1'b1;
    bus.audio_l = 16'hC005;
    bus.audio_r = 16'h0C05;
    @(negedge clk);
    bus.sample_ce = 1'b0;
    chk("full_coinc_overrun", bus.overrun, 0);
    chk("full_coinc_level", bus.fifo_level, 4);
    repeat (5) wait_t(8);
    wait_t(8);
    send(16'hD00D, 16'hF00D);
    chk("pre_rst_level", bus.fifo_level, 1);
    wait_t(168);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_sclk", bus.i2s_sclk, 0);
    chk("mid_rst_lrclk", bus.i2s_lrclk, 1);
    chk("mid_rst_sdata", bus.i2s_sdata, 0);
    chk("mid_rst_overrun", bus.overrun, 0);
    chk("mid_rst_underrun", bus.underrun, 0);
    chk("mid_rst_level", bus.fifo_level, 0);
    reset = 1'b0;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (!bus.i2s_lrclk) break;
    end
    chk("restart_cycles", n, 8);
    repeat (3) wait_t(8);
    chk("frames_seen", nfr >= 18, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_RATE, default 24576000, system clock frequency in Hz.
REQ-002 SHALL have parameter AUDIO_RATE, default 48000, output frame rate in Hz.
REQ-003 SHALL derive HALF_DIV = CLK_RATE/(AUDIO_RATE*128), the clk cycles per half SCLK period; CLK_RATE SHALL be an exact multiple of AUDIO_RATE*128, giving HALF_DIV>=1, and HALF_DIV is 4 at the defaults.
REQ-004 SHALL have port clk, input, 1 bit, the system clock; every register SHALL be clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port sample_ce, input, 1 bit, a one-clk strobe marking a valid stereo sample.
REQ-007 SHALL have ports audio_l and audio_r, input, 16 bits each, signed PCM samples captured on sample_ce.
REQ-008 SHALL have port i2s_sclk, output, 1 bit, the bit clock.
REQ-009 SHALL have port i2s_lrclk, output, 1 bit, word select: 0 = left, 1 = right.
REQ-010 SHALL have port i2s_sdata, output, 1 bit, serial data.
REQ-011 SHALL have ports overrun and underrun, output, 1 bit each, one-clk event pulses.
REQ-012 SHALL have port fifo_level, output, 3 bits, current FIFO occupancy from 0 to 4.

Function
REQ-013 SHALL implement a 4-entry, 32-bit FIFO holding {audio_l, audio_r}, with 2-bit wrapping read and write pointers.
REQ-014 SHALL write on sample_ce when the FIFO is not full; on sample_ce with the FIFO full and no pop in the same cycle, SHALL drop the sample and pulse overrun for 1 clk.
REQ-015 SHALL run a divider from 0 to HALF_DIV-1 continuously and toggle i2s_sclk when it reaches HALF_DIV-1.
REQ-016 SHALL advance a 6-bit frame position p (0..63, wrapping from 63 to 0) on each clk where i2s_sclk toggles from 1 to 0, with i2s_sdata and i2s_lrclk updating in that same cycle.
REQ-017 SHALL drive i2s_lrclk=0 for p=0..31 and i2s_lrclk=1 for p=32..63.
REQ-018 SHALL drive i2s_sdata as follows, giving standard I2S one-bit delay, MSB first, with 16 data bits left-justified in a 32-bit slot:
- p=1..16: left[16-p]
- p=33..48: right[48-p]
- all other p: 0
REQ-019 SHALL, on the falling-edge cycle that enters p=0, pop the FIFO head into the frame shift register if the FIFO is non-empty.
REQ-020 SHALL, on that same p=0 cycle with the FIFO empty, pulse underrun for 1 clk and load the fallback frame defined under Configuration.
REQ-021 SHALL accept the write when a pop and sample_ce coincide with the FIFO full; fifo_level SHALL stay at 4 and overrun SHALL NOT pulse.
REQ-022 SHALL, when a pop attempt and sample_ce coincide with the FIFO empty, report underrun and accept the write, leaving fifo_level at 1.
REQ-023 SHALL change fifo_level by +1 or -1 one clk after a write or pop, and by 0 when both occur in the same cycle.
REQ-024 SHALL latch sample data only at p=0, so FIFO writes during a frame never alter the frame being shifted.

Reset
REQ-025 SHALL, on a clk edge with reset=1, drive i2s_sclk=0, i2s_lrclk=1, i2s_sdata=0, overrun=0, underrun=0, fifo_level=0.
REQ-026 SHALL, on reset, clear the divider, set p=63, empty the FIFO and clear the shift register and the held frame to 0.
REQ-027 SHALL, when reset is asserted mid-frame, abort the frame in that cycle with no partial-bit completion; the first falling edge after release SHALL enter p=0.
REQ-028 SHALL ignore sample_ce during any cycle in which reset=1.

Configuration
REQ-029 SHALL use the macro I2S_TX_HOLD_EN to select the underrun fallback frame.
REQ-030 SHALL, with I2S_TX_HOLD_EN defined, retransmit the last successfully popped frame on underrun, or zeros if no frame has been popped since reset.
REQ-031 SHALL, with I2S_TX_HOLD_EN undefined, transmit an all-zero frame on underrun and omit the held-frame register.

Verification
REQ-032 Default parameters, one sample_ce with L=16'hA5C3, R=16'h0F01 before the first p=0 -> SCLK period of 8 clk, LRCLK period of 512 clk, SDATA bits 1..16 = A5C3 MSB first, bits 33..48 = 0F01 MSB first, all other bits 0.
REQ-033 Five sample_ce pulses with no pop in between -> fifo_level reaches 4 and a single overrun pulse on the fifth; the fifth sample is never transmitted.
REQ-034 No sample_ce after reset -> underrun pulses at every p=0 and SDATA stays 0, in both macro builds.
REQ-035 Send one frame of 16'h1234/16'h5678 and then starve the FIFO -> the next frame repeats 1234/5678 with I2S_TX_HOLD_EN defined and is all zeros without it.
REQ-036 FIFO full and sample_ce coinciding with the pop at p=0 -> no overrun, fifo_level stays 4, and the new sample is delivered 4 frames later.
REQ-037 Assert reset for 1 clk at p=20 -> outputs return to their reset values next cycle, fifo_level=0, and the next frame begins at p=0 with LRCLK falling.
